// File: rtl/fp32_pkg.sv
// Shared FP32 constants for the add/sub pipeline: field widths, bias, canonical
// quiet NaN and the bit positions inside the front-end exception vector.
package fp32_pkg;
  localparam int FP_EW = 8;
  localparam int FP_MW = 23;
  localparam int FP_BIAS = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [FP_EW-1:0] FP_EXP_MAX = 8'hFF;

  // InputExc = {any, ANaN, BNaN, AInf, BInf}
  localparam int EXC_ANY  = 4;
  localparam int EXC_ANAN = 3;
  localparam int EXC_BNAN = 2;
  localparam int EXC_AINF = 1;
  localparam int EXC_BINF = 0;
endpackage

// File: rtl/lzc24.sv
// Combinational 24-bit leading-zero counter; reports 24 for an all-zero input.
module lzc24 (
  input  logic [23:0] din,
  output logic [4:0]  count
);
  // Scanning upward lets the highest set bit have the final say.
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (din[i]) count = 5'(23 - i);
    end
  end
endmodule

// File: rtl/fp_addsub_exec_norm.sv
// FP32 add/sub back end: effective mantissa add/sub, normalization, special-case
// override and packing, in two valid/ready pipeline registers.
module fp_addsub_exec_norm
  import fp32_pkg::*;
#(
  parameter int          MW   = FP_MW,
  parameter int          EW   = FP_EW,
  parameter logic [31:0] QNAN = FP_QNAN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          Opout,
  input  logic          Sa,
  input  logic          Sb,
  input  logic          MaxAB,
  input  logic [EW-1:0] CExp,
  input  logic [MW-1:0] Mmax,
  input  logic [MW:0]   Mmin_3,
  input  logic [4:0]    InputExc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   Result,
  output logic [3:0]    Flags
);
  localparam int SW = MW + 2;

  logic          s2_load, s1_adv;
  logic          s1_valid, s1_sgn, s1_eop;
  logic [SW-1:0] s1_sum;
  logic [EW-1:0] s1_exp;
  logic [4:0]    s1_exc;

  logic          eop_d, sgn_d;
  logic [MW:0]   m_big;
  logic [SW-1:0] sum_d;
  logic [4:0]    lz;
  logic [MW:0]   norm;
  logic [EW:0]   exp_inc;
  logic [EW-1:0] exp_sub;
  logic [31:0]   res_d;
  logic [3:0]    flg_d;

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_load;
  assign in_ready = s1_adv;

  // M >= Mmin_3 is guaranteed upstream, so the subtract never goes negative.
  assign eop_d = Sa ^ Sb ^ Opout;
  assign m_big = {1'b1, Mmax};
  assign sum_d = eop_d ? ({1'b0, m_big} - {1'b0, Mmin_3})
                       : ({1'b0, m_big} + {1'b0, Mmin_3});
  assign sgn_d = MaxAB ? (Sb ^ Opout) : Sa;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_sgn   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_exp   <= '0;
      s1_exc   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum <= sum_d;
        s1_sgn <= sgn_d;
        s1_eop <= eop_d;
        s1_exp <= CExp;
        s1_exc <= InputExc;
      end
    end
  end

  lzc24 u_lzc (
    .din   (s1_sum[MW:0]),
    .count (lz)
  );

  assign norm    = s1_sum[MW:0] << lz;
  assign exp_inc = {1'b0, s1_exp} + {{EW{1'b0}}, 1'b1};
  assign exp_sub = s1_exp - {{(EW-5){1'b0}}, lz};

  always_comb begin
    res_d = '0;
    flg_d = '0;
    if (s1_sum[SW-1]) begin
      if (exp_inc >= {1'b0, FP_EXP_MAX}) begin
        res_d    = {s1_sgn, FP_EXP_MAX, {MW{1'b0}}};
        flg_d[2] = 1'b1;
      end else begin
        res_d = {s1_sgn, exp_inc[EW-1:0], s1_sum[MW:1]};
      end
    end else if (s1_sum == '0) begin
      // Exact cancellation yields +0; a true add of two zeros keeps the sign.
      res_d    = {!s1_eop && s1_sgn, {(EW+MW){1'b0}}};
      flg_d[0] = 1'b1;
    end else if ({{(EW-5){1'b0}}, lz} >= s1_exp) begin
      res_d = {s1_sgn, {(EW+MW){1'b0}}};
      flg_d = 4'b0011;
    end else begin
      res_d = {s1_sgn, exp_sub, norm[MW-1:0]};
    end

    if (s1_exc[EXC_ANAN] || s1_exc[EXC_BNAN]) begin
      res_d = QNAN;
      flg_d = 4'b1000;
    end else if (s1_exc[EXC_AINF] && s1_exc[EXC_BINF] && s1_eop) begin
      res_d = QNAN;
      flg_d = 4'b1000;
    end else if (s1_exc[EXC_AINF] || s1_exc[EXC_BINF]) begin
      res_d = {s1_sgn, FP_EXP_MAX, {MW{1'b0}}};
      flg_d = 4'b0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Flags     <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Result <= res_d;
        Flags  <= flg_d;
      end
    end
  end
endmodule
